block_mover: RTL and testbench

Moves the active block along its row and reports where the player dropped it. At the start of each row it loads the start position and direction produced by the row counter. On each step tick it shifts the block horizontally and bounces at the row edges. When the player presses drop, it latches the final column and sends a one-cycle `inc_row` back to the row counter. The block sits between the row counter, the frame-tick generator, the player key input and the drawing/scoring logic.

---
 rtl/block_mover.sv | 154 +++++++++++++++
 tb/tb_block_mover.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_mover.sv
// block_mover: moves the active block along its row, bounces at the edges, reports the drop column.
// Latency: all outputs registered; start/step/drop take effect on the edge they are sampled.
// Backpressure: none; inputs are sampled every cycle, start is ignored outside IDLE, drop outside MOVE.
//
// Ports:
//   clk, reset                         clock and synchronous active-high reset
//   start, new_x/y_position, new_direction   row start values from the row counter
//   move_tick, drop                    frame tick and player drop request
//   x_pos, y_pos, direction, moving    current block state for the drawing logic
//   inc_row, placed_valid, placed_x    one-cycle drop report to row counter / scoring
module block_mover #(
  parameter logic [7:0] X_MIN     = 8'd0,
  parameter logic [7:0] X_MAX     = 8'd144,
  parameter logic [7:0] STEP      = 8'd1,
  parameter int         SPEED_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] new_x_position,
  input  logic [6:0] new_y_position,
  input  logic       new_direction,
  input  logic       move_tick,
  input  logic       drop,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       direction,
  output logic       moving,
  output logic       inc_row,
  output logic       placed_valid,
  output logic [7:0] placed_x
);

  localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_PLACE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic             dir_q, dir_d;
  logic             moving_q, moving_d;
  logic             inc_row_q, inc_row_d;
  logic             placed_valid_q, placed_valid_d;
  logic [7:0]       placed_x_q, placed_x_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    dir_d          = dir_q;
    moving_d       = 1'b0;
    inc_row_d      = 1'b0;
    placed_valid_d = 1'b0;
    placed_x_d     = placed_x_q;
    div_d          = div_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Out-of-range start columns are pulled onto the nearer edge.
          if (new_x_position <= X_MIN)      x_d = X_MIN;
          else if (new_x_position >= X_MAX) x_d = X_MAX;
          else                              x_d = new_x_position;
          y_d      = new_y_position;
          dir_d    = new_direction;
          div_d    = '0;
          moving_d = 1'b1;
          state_d  = S_MOVE;
        end
      end

      S_MOVE: begin
        moving_d = 1'b1;
        if (drop) begin
          // Drop takes priority: the column is frozen and the divider holds.
          placed_x_d     = x_q;
          inc_row_d      = 1'b1;
          placed_valid_d = 1'b1;
          moving_d       = 1'b0;
          state_d        = S_PLACE;
        end else if (move_tick) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            // Edge tests in 9 bits so x+STEP cannot wrap; the direction flips
            // on the same edge the block lands on the boundary.
            if (dir_q) begin
              if (9'(x_q) + 9'(STEP) >= 9'(X_MAX)) begin
                x_d   = X_MAX;
                dir_d = 1'b0;
              end else begin
                x_d = x_q + STEP;
              end
            end else begin
              if (9'(x_q) <= 9'(X_MIN) + 9'(STEP)) begin
                x_d   = X_MIN;
                dir_d = 1'b1;
              end else begin
                x_d = x_q - STEP;
              end
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end

      S_PLACE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      x_q            <= X_MIN;
      y_q            <= 7'd104;
      dir_q          <= 1'b1;
      moving_q       <= 1'b0;
      inc_row_q      <= 1'b0;
      placed_valid_q <= 1'b0;
      placed_x_q     <= 8'd0;
      div_q          <= '0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      dir_q          <= dir_d;
      moving_q       <= moving_d;
      inc_row_q      <= inc_row_d;
      placed_valid_q <= placed_valid_d;
      placed_x_q     <= placed_x_d;
      div_q          <= div_d;
    end
  end

  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign direction    = dir_q;
  assign moving       = moving_q;
  assign inc_row      = inc_row_q;
  assign placed_valid = placed_valid_q;
  assign placed_x     = placed_x_q;

endmodule

// File: tb/tb_block_mover.sv
// Bench for block_mover: three instances share one stimulus stream.
//   inst0: STEP=1 SPEED_DIV=1, inst1: STEP=1 SPEED_DIV=4, inst2: STEP=4 SPEED_DIV=1
module tb_block_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] new_x_position = 8'd0;
  logic [6:0] new_y_position = 7'd0;
  logic       new_direction = 1'b0;
  logic       move_tick = 1'b0;
  logic       drop = 1'b0;

  logic [7:0] xo  [3];
  logic [6:0] yo  [3];
  logic       dro [3];
  logic       mvo [3];
  logic       iro [3];
  logic       pvo [3];
  logic [7:0] pxo [3];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    block_mover #(
      .X_MIN(8'd0),
      .X_MAX(8'd144),
      .STEP(g == 2 ? 8'd4 : 8'd1),
      .SPEED_DIV(g == 1 ? 4 : 1)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .new_x_position(new_x_position),
      .new_y_position(new_y_position),
      .new_direction(new_direction),
      .move_tick(move_tick),
      .drop(drop),
      .x_pos(xo[g]),
      .y_pos(yo[g]),
      .direction(dro[g]),
      .moving(mvo[g]),
      .inc_row(iro[g]),
      .placed_valid(pvo[g]),
      .placed_x(pxo[g])
    );
  end

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for a row, 1 block sliding, 2 drop being reported
  int m_mode [3];
  int m_x    [3];
  int m_y    [3];
  int m_dir  [3];
  int m_tk   [3];
  int m_px   [3];
  int m_pls  [3];
  int p_step [3] = '{1, 1, 4};
  int p_div  [3] = '{1, 4, 1};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_mode[i] = 0; m_x[i] = 0; m_y[i] = 104; m_dir[i] = 1;
        m_tk[i] = 0; m_px[i] = 0; m_pls[i] = 0;
      end else if (m_mode[i] == 0) begin
        m_pls[i] = 0;
        if (start) begin
          m_x[i]    = (int'(new_x_position) > 144) ? 144 : int'(new_x_position);
          m_y[i]    = int'(new_y_position);
          m_dir[i]  = int'(new_direction);
          m_tk[i]   = 0;
          m_mode[i] = 1;
        end
      end else if (m_mode[i] == 1) begin
        if (drop) begin
          m_px[i] = m_x[i]; m_pls[i] = 1; m_mode[i] = 2;
        end else if (move_tick) begin
          m_tk[i]++;
          if (m_tk[i] == p_div[i]) begin
            m_tk[i] = 0;
            if (m_dir[i] == 1) begin
              if (m_x[i] + p_step[i] >= 144) begin m_x[i] = 144; m_dir[i] = 0; end
              else m_x[i] = m_x[i] + p_step[i];
            end else begin
              if (m_x[i] <= p_step[i]) begin m_x[i] = 0; m_dir[i] = 1; end
              else m_x[i] = m_x[i] - p_step[i];
            end
          end
        end
      end else begin
        m_pls[i] = 0; m_mode[i] = 0;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (xo[i] !== 8'(m_x[i]) || yo[i] !== 7'(m_y[i]) || dro[i] !== 1'(m_dir[i]) ||
            mvo[i] !== (m_mode[i] == 1) || iro[i] !== 1'(m_pls[i]) ||
            pvo[i] !== 1'(m_pls[i]) || pxo[i] !== 8'(m_px[i])) begin
          bad++;
          $display("FAIL model inst%0d t=%0t: got x=%0d y=%0d dir=%0b mv=%0b inc=%0b pv=%0b px=%0d, want x=%0d y=%0d dir=%0d mv=%0d inc=%0d pv=%0d px=%0d",
                   i, $time, xo[i], yo[i], dro[i], mvo[i], iro[i], pvo[i], pxo[i],
                   m_x[i], m_y[i], m_dir[i], (m_mode[i] == 1), m_pls[i], m_pls[i], m_px[i]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_start(input int x, input int y, input bit d);
    new_x_position = 8'(x);
    new_y_position = 7'(y);
    new_direction  = d;
    start = 1'b1;
    edge1();
    start = 1'b0;
  endtask

  task automatic tick();
    move_tick = 1'b1;
    edge1();
    move_tick = 1'b0;
    edge1();
  endtask

  task automatic drop_and_idle();
    drop = 1'b1;
    edge1();
    drop = 1'b0;
    edge1();
  endtask

  initial begin
    // Reset for two cycles.
    reset = 1'b1;
    @(posedge clk);
    #1 chk_en = 1;
    edge1();
    reset = 1'b0;
    edge1();
    chk("rst_x",   32'(xo[0]), 0);
    chk("rst_y",   32'(yo[0]), 104);
    chk("rst_dir", 32'(dro[0]), 1);
    chk("rst_mv",  32'(mvo[0]), 0);
    chk("rst_inc", 32'(iro[0]), 0);
    chk("rst_pv",  32'(pvo[0]), 0);

    // Stepping and divider.
    do_start(0, 104, 1'b1);
    chk("start_mv", 32'(mvo[0]), 1);
    repeat (3) tick();
    chk("div1_3ticks", 32'(xo[0]), 3);
    chk("div4_3ticks", 32'(xo[1]), 0);
    repeat (4) tick();
    chk("div4_7ticks", 32'(xo[1]), 1);
    chk("step4_7ticks", 32'(xo[2]), 28);
    drop = 1'b1;
    edge1();
    drop = 1'b0;
    chk("drop_px", 32'(pxo[0]), 7);
    chk("drop_inc", 32'(iro[0]), 1);
    edge1();

    // Right bounce.
    do_start(142, 104, 1'b1);
    tick();
    chk("rb_x1", 32'(xo[0]), 143);
    chk("rb_s4_x1", 32'(xo[2]), 144);
    tick();
    chk("rb_x2", 32'(xo[0]), 144);
    chk("rb_dir2", 32'(dro[0]), 0);
    tick();
    chk("rb_x3", 32'(xo[0]), 143);
    drop_and_idle();

    // Left bounce.
    do_start(6, 104, 1'b0);
    tick();
    chk("lb_x1", 32'(xo[2]), 2);
    tick();
    chk("lb_x2", 32'(xo[2]), 0);
    chk("lb_dir2", 32'(dro[2]), 1);
    drop_and_idle();

    // Drop together with a tick, drop held for five cycles; start ignored while moving.
    do_start(10, 60, 1'b1);
    do_start(77, 5, 1'b0);
    chk("start_ign", 32'(xo[0]), 10);
    drop = 1'b1;
    move_tick = 1'b1;
    edge1();
    move_tick = 1'b0;
    chk("dt_px", 32'(pxo[0]), 10);
    chk("dt_x", 32'(xo[0]), 10);
    chk("dt_pv", 32'(pvo[0]), 1);
    chk("dt_mv", 32'(mvo[0]), 0);
    edge1();
    chk("dt_inc_off", 32'(iro[0]), 0);
    repeat (3) edge1();
    drop = 1'b0;
    chk("idle_drop_pv", 32'(pvo[0]), 0);
    edge1();

    // Reset mid-move, then reload.
    do_start(50, 30, 1'b1);
    tick();
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    chk("rm_x", 32'(xo[0]), 0);
    chk("rm_y", 32'(yo[0]), 104);
    chk("rm_inc", 32'(iro[0]), 0);
    chk("rm_px", 32'(pxo[0]), 0);
    do_start(144, 88, 1'b0);
    chk("rl_x", 32'(xo[0]), 144);
    chk("rl_y", 32'(yo[0]), 88);
    chk("rl_dir", 32'(dro[0]), 0);
    chk("rl_mv", 32'(mvo[0]), 1);
    tick();

    // Reset while reporting a drop: no pulse survives.
    drop = 1'b1;
    edge1();
    drop = 1'b0;
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    chk("rp_inc", 32'(iro[0]), 0);
    edge1();

    // Out-of-range start column is clamped.
    do_start(200, 10, 1'b1);
    chk("clamp_x", 32'(xo[0]), 144);
    tick();
    chk("clamp_dir", 32'(dro[0]), 0);
    drop_and_idle();
    edge1();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
